// File: rtl/invaders_pkg.sv
// Shared constants and fire FSM encoding for the invaders input path.
package invaders_pkg;

   // Default timing at 100 MHz
   localparam int unsigned DEF_DB_CYCLES  = 1_000_000;   // 10 ms debounce
   localparam int unsigned DEF_RPT_DELAY  = 25_000_000;  // 250 ms before first repeat
   localparam int unsigned DEF_RPT_PERIOD = 5_000_000;   // 50 ms between repeats
   localparam int unsigned DEF_FIRE_CD    = 30_000_000;  // 300 ms fire cooldown

   typedef enum logic [1:0] {
      FIRE_IDLE     = 2'd0,
      FIRE_REQ      = 2'd1,
      FIRE_COOLDOWN = 2'd2
   } fire_state_t;

   // Width of a counter that must hold values up to n without wrapping
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/btn_sync_db.sv
// Two-flop synchronizer followed by a debounce counter for one push-button.
module btn_sync_db
   import invaders_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int unsigned   CW   = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchronize the raw level, then accept it after DB_CYCLES stable cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/input_ctrl.sv
// Player input controller: debounced buttons, move pulses with auto-repeat,
// and a fire request handshake with cooldown.
module input_ctrl
   import invaders_pkg::*;
#(
   parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
   parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
   parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD,
   parameter int unsigned FIRE_CD    = DEF_FIRE_CD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_fire,
   input  logic       game_en,
   input  logic       shot_active,
   input  logic       fire_ack,
   output logic [2:0] btn_state,
   output logic       move_left,
   output logic       move_right,
   output logic       fire_req
);

   localparam int unsigned   RMAX        = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int unsigned   RW          = cnt_width(RMAX);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD - 1);
   localparam int unsigned   FW          = cnt_width(FIRE_CD);
   localparam logic [FW-1:0] FIRE_LAST   = FW'(FIRE_CD - 1);

   btn_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_left (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_left),
      .level (btn_state[0])
   );

   btn_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_right (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_right),
      .level (btn_state[1])
   );

   btn_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_fire (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_fire),
      .level (btn_state[2])
   );

   // Index 0 = left, 1 = right. A direction only moves while held alone, so
   // the rise of "alone" covers both a fresh press and the survivor of a
   // left+right conflict.
   logic [1:0]         alone;
   logic [1:0]         alone_prev;
   logic [1:0]         move_q;
   logic [1:0]         rpt_phase;
   logic [1:0][RW-1:0] rpt_cnt;

   assign alone[0]   = btn_state[0] & ~btn_state[1];
   assign alone[1]   = btn_state[1] & ~btn_state[0];
   assign move_left  = move_q[0];
   assign move_right = move_q[1];

   // Initial pulse, then repeat after RPT_DELAY and every RPT_PERIOD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alone_prev <= '0;
         move_q     <= '0;
         rpt_phase  <= '0;
         rpt_cnt    <= '0;
      end else begin
         alone_prev <= alone;
         for (int unsigned d = 0; d < 2; d++) begin
            move_q[d] <= 1'b0;
            if (!game_en || !alone[d]) begin
               rpt_cnt[d]   <= '0;
               rpt_phase[d] <= 1'b0;
            end else if (!alone_prev[d]) begin
               move_q[d]    <= 1'b1;
               rpt_cnt[d]   <= '0;
               rpt_phase[d] <= 1'b0;
            end else if (rpt_cnt[d] == (rpt_phase[d] ? PERIOD_LAST : DELAY_LAST)) begin
               move_q[d]    <= 1'b1;
               rpt_cnt[d]   <= '0;
               rpt_phase[d] <= 1'b1;
            end else begin
               rpt_cnt[d] <= rpt_cnt[d] + RW'(1);
            end
         end
      end
   end

   fire_state_t   fire_state;
   logic          fire_prev;
   logic          fire_rise;
   logic [FW-1:0] cd_cnt;

   assign fire_rise = btn_state[2] & ~fire_prev;

   // Fire FSM: edge-triggered request, held until acknowledged, then cooldown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fire_state <= FIRE_IDLE;
         fire_req   <= 1'b0;
         fire_prev  <= 1'b0;
         cd_cnt     <= '0;
      end else begin
         fire_prev <= btn_state[2];
         case (fire_state)
            FIRE_IDLE: begin
               cd_cnt <= '0;
               if (fire_rise && game_en && !shot_active) begin
                  fire_state <= FIRE_REQ;
                  fire_req   <= 1'b1;
               end
            end
            FIRE_REQ: begin
               if (!game_en) begin
                  fire_state <= FIRE_IDLE;
                  fire_req   <= 1'b0;
               end else if (fire_ack) begin
                  fire_state <= FIRE_COOLDOWN;
                  fire_req   <= 1'b0;
                  cd_cnt     <= '0;
               end
            end
            FIRE_COOLDOWN: begin
               if (!game_en || cd_cnt == FIRE_LAST) begin
                  fire_state <= FIRE_IDLE;
                  cd_cnt     <= '0;
               end else begin
                  cd_cnt <= cd_cnt + FW'(1);
               end
            end
            default: begin
               fire_state <= FIRE_IDLE;
               fire_req   <= 1'b0;
               cd_cnt     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_ctrl.sv
// Scoreboard bench for input_ctrl with short timing parameters.
module tb_input_ctrl;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;
   localparam int FC = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_left, btn_right, btn_fire;
   logic       game_en, shot_active, fire_ack;
   logic [2:0] btn_state;
   logic       move_left, move_right, fire_req;

   input_ctrl #(
      .DB_CYCLES  (DB),
      .RPT_DELAY  (RD),
      .RPT_PERIOD (RP),
      .FIRE_CD    (FC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_fire    (btn_fire),
      .game_en     (game_en),
      .shot_active (shot_active),
      .fire_ack    (fire_ack),
      .btn_state   (btn_state),
      .move_left   (move_left),
      .move_right  (move_right),
      .fire_req    (fire_req)
   );

   always #5 clk = ~clk;

   // Cycle label: inputs driven after posedge N and outputs seen at the
   // following negedge both belong to cycle N.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   // Event kinds: 0 move_left pulse, 1 move_right pulse, 2 fire_req rise, 3 fire_req fall
   typedef struct {
      int kind;
      int cyc;
   } ev_t;
   ev_t exp_q[$];

   function automatic string kname(int k);
      case (k)
         0:       return "move_left";
         1:       return "move_right";
         2:       return "fire_req_rise";
         default: return "fire_req_fall";
      endcase
   endfunction

   task automatic expect_ev(int kind, int c);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // A direction held alone for `len` btn_state cycles, first pulse at `first`:
   // pulses at offsets 0, RD, RD+RP, RD+2RP, ... that stay below len.
   task automatic push_moves(int kind, int first, int len);
      int off = 0;
      while (off <= len - 1) begin
         expect_ev(kind, first + off);
         off = (off == 0) ? RD : off + RP;
      end
   endtask

   task automatic check(string name, int actual, int required);
      vectors++;
      if (actual != required) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   task automatic observe(int kind);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_%s: seen at cycle %0d, none expected", kname(kind), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc) begin
            miscompares++;
            $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                     kname(kind), cyc, kname(e.kind), e.cyc);
         end
      end
   endtask

   // Monitor: turn DUT outputs into events and match them against the queue
   initial begin : monitor
      logic fr_prev;
      ev_t  m;
      fr_prev = 1'b0;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            m = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_%s: nothing seen by cycle %0d, expected at cycle %0d",
                     kname(m.kind), cyc, m.cyc);
         end
         if (move_left)             observe(0);
         if (move_right)            observe(1);
         if (fire_req && !fr_prev)  observe(2);
         if (!fire_req && fr_prev)  observe(3);
         fr_prev = fire_req;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(int c);
      while (cyc < c) step();
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   // Clean press of one direction held for `hold` cycles (raw)
   task automatic press_move(int dir, int hold);
      int p = cyc;
      if (dir == 0) btn_left = 1'b1; else btn_right = 1'b1;
      push_moves(dir, p + DB + 3, hold);
      goto(p + hold);
      btn_left  = 1'b0;
      btn_right = 1'b0;
      idle(14);
   endtask

   // Fire press acknowledged after `a` REQ cycles; optionally blocked by shot_active
   task automatic fire_shot(int a, bit blocked);
      int p = cyc;
      shot_active = blocked;
      btn_fire    = 1'b1;
      if (!blocked) begin
         expect_ev(2, p + DB + 3);
         expect_ev(3, p + DB + 3 + a);
      end
      goto(p + DB + 2 + a);
      if (!blocked) fire_ack = 1'b1;
      step();
      fire_ack    = 1'b0;
      btn_fire    = 1'b0;
      shot_active = 1'b0;
      idle(FC + 14);
   endtask

   initial begin : stimulus
      int p, r, q2, d1, d2, d3;

      rst_n       = 1'b0;
      btn_left    = 1'b1;   // held through reset release
      btn_right   = 1'b0;
      btn_fire    = 1'b0;
      game_en     = 1'b1;
      shot_active = 1'b0;
      fire_ack    = 1'b0;

      // Reset state, with a button already pressed
      idle(4);
      @(negedge clk);
      check("reset_outputs", {btn_state, move_left, move_right, fire_req}, 0);
      step();
      rst_n = 1'b1;
      r = cyc;
      push_moves(0, r + DB + 3, 10);
      goto(r + 10);
      btn_left = 1'b0;
      idle(14);

      // Bounce: toggle every 2 cycles for 20 cycles, then steady 1
      p = cyc;
      push_moves(0, p + 20 + DB + 3, 30);
      for (int c = 0; c <= 26; c++) begin
         goto(p + c);
         btn_left = (c >= 20) ? 1'b1 : (((c / 2) % 2) == 0);
         @(negedge clk);
         check("bounce_btn_state_left", int'(btn_state[0]), (c >= 20 + DB + 2) ? 1 : 0);
      end
      goto(p + 50);
      btn_left = 1'b0;
      idle(14);

      // Auto-repeat on a 60-cycle hold
      press_move(1, 60);

      // Conflict: left held, right pressed and released
      for (int k = 0; k < 3; k++) begin
         d1 = (k == 0) ? 30 : int'($urandom_range(10, 40));
         d2 = int'($urandom_range(10, 30));
         d3 = int'($urandom_range(10, 50));
         p = cyc;
         btn_left = 1'b1;
         push_moves(0, p + DB + 3, d1);
         goto(p + d1);
         btn_right = 1'b1;
         goto(p + d1 + d2);
         btn_right = 1'b0;
         q2 = cyc;
         push_moves(0, q2 + DB + 3, d3);
         goto(q2 + d3);
         btn_left = 1'b0;
         idle(14);
      end

      // Random single-direction presses
      for (int k = 0; k < 6; k++) begin
         press_move(int'($urandom_range(0, 1)), int'($urandom_range(6, 70)));
      end

      // Fire handshake: ack on cycle 5 of REQ, second press during cooldown
      p = cyc;
      btn_fire = 1'b1;
      expect_ev(2, p + 7);
      expect_ev(3, p + 12);
      goto(p + 11);
      fire_ack = 1'b1;
      step();
      fire_ack = 1'b0;
      btn_fire = 1'b0;
      goto(p + 20);
      btn_fire = 1'b1;          // debounced inside cooldown, held past its end
      goto(p + 60);
      @(negedge clk);
      check("no_autofire", int'(fire_req), 0);
      btn_fire = 1'b0;
      idle(14);

      // Random fire handshakes, some blocked by shot_active
      for (int k = 0; k < 5; k++) begin
         fire_shot(int'($urandom_range(1, 8)), ($urandom_range(0, 2) == 0));
      end

      // Blocking: shot_active
      fire_shot(3, 1'b1);

      // Blocking: game_en low suppresses moves and fire but not btn_state
      game_en  = 1'b0;
      p = cyc;
      btn_fire = 1'b1;
      btn_left = 1'b1;
      goto(p + 8);
      @(negedge clk);
      check("btn_state_while_disabled", int'(btn_state), 5);
      goto(p + 40);
      btn_fire = 1'b0;
      btn_left = 1'b0;
      idle(14);
      game_en = 1'b1;
      idle(2);

      // game_en dropped during REQ
      p = cyc;
      btn_fire = 1'b1;
      expect_ev(2, p + 7);
      expect_ev(3, p + 10);
      goto(p + 9);
      game_en = 1'b0;
      goto(p + 12);
      game_en  = 1'b1;
      btn_fire = 1'b0;
      idle(14);

      // Reset mid-cooldown with fire held
      p = cyc;
      btn_fire = 1'b1;
      expect_ev(2, p + 7);
      expect_ev(3, p + 12);
      goto(p + 11);
      fire_ack = 1'b1;
      step();
      fire_ack = 1'b0;
      goto(p + 20);
      @(negedge clk);
      check("fire_level_before_reset", int'(btn_state), 4);
      #2;
      rst_n = 1'b0;
      #1;
      check("outputs_in_reset", {btn_state, move_left, move_right, fire_req}, 0);
      goto(p + 23);
      rst_n = 1'b1;
      r = cyc;
      expect_ev(2, r + DB + 3);
      expect_ev(3, r + DB + 5);
      goto(r + DB + 4);
      fire_ack = 1'b1;
      step();
      fire_ack = 1'b0;
      btn_fire = 1'b0;
      idle(FC + 14);

      idle(20);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
